swap_ctrl: RTL and testbench

SWAP_CTRL -- requirements
Module: swap_ctrl

---
 rtl/swap_ctrl_pkg.sv | 20 ++
 rtl/swap_ctrl.sv | 162 ++++++++++++++++
 tb/tb_swap_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/swap_ctrl_pkg.sv
// Shared definitions for the register swap controller: FSM state encoding
// and the default widths of the register-file data and address buses.
package swap_ctrl_pkg;

    // Default register-file data width
    localparam int DATA_W_DEFAULT = 32;

    // Default register-file address width
    localparam int ADDR_W_DEFAULT = 4;

    // Swap sequence states, 3-bit encoded
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WR_RS = 3'd2,
        WR_RT = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage : swap_ctrl_pkg

// File: rtl/swap_ctrl.sv
// Register swap controller. Exchanges the contents of two register-file
// entries Rs and Rt using one read cycle and two write cycles through an
// external address mux (in_a = swap_a, in_b = swap_b, select = swap_sel).
// When Rs and Rt are the same register the write cycles are skipped.
//
// All outputs are registered. Their next values are derived from the
// next state, so each output changes on the same edge that enters the
// state it belongs to.
module swap_ctrl
    import swap_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              start,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0] rd_data_1,
    input  logic [DATA_W-1:0] rd_data_2,
    output logic [ADDR_W-1:0] swap_a,
    output logic [ADDR_W-1:0] swap_b,
    output logic              swap_sel,
    output logic              rf_we,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    // State and datapath registers
    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-1:0]   swap_a_q;
    logic [ADDR_W-1:0]   swap_a_d;
    logic [ADDR_W-1:0]   swap_b_q;
    logic [ADDR_W-1:0]   swap_b_d;
    logic [DATA_W-1:0]   tmp_rs_q;
    logic [DATA_W-1:0]   tmp_rs_d;
    logic [DATA_W-1:0]   tmp_rt_q;
    logic [DATA_W-1:0]   tmp_rt_d;

    // Registered outputs
    logic                swap_sel_q;
    logic                swap_sel_d;
    logic                rf_we_q;
    logic                rf_we_d;
    logic [DATA_W-1:0]   wr_data_q;
    logic [DATA_W-1:0]   wr_data_d;
    logic                busy_q;
    logic                busy_d;
    logic                done_q;
    logic                done_d;

    // Next-state logic: transitions, address latching and operand capture
    always_comb begin
        state_d  = state_q;
        swap_a_d = swap_a_q;
        swap_b_d = swap_b_q;
        tmp_rs_d = tmp_rs_q;
        tmp_rt_d = tmp_rt_q;
        case (state_q)
            IDLE: begin
                // Start is only honoured here; in other states it is dropped
                if (start) begin
                    swap_a_d = rs_addr;
                    swap_b_d = rt_addr;
                    state_d  = READ;
                end else begin
                    state_d  = IDLE;
                end
            end
            READ: begin
                tmp_rs_d = rd_data_1;
                tmp_rt_d = rd_data_2;
                // Swapping a register with itself is a no-op: skip writes
                if (swap_a_q == swap_b_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WR_RS;
                end
            end
            WR_RS: begin
                state_d = WR_RT;
            end
            WR_RT: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so registered outputs line up with it
    always_comb begin
        swap_sel_d = 1'b0;
        rf_we_d    = 1'b0;
        wr_data_d  = {DATA_W{1'b0}};
        done_d     = 1'b0;
        busy_d     = (state_d != IDLE);
        case (state_d)
            WR_RS: begin
                // Rs slot receives the old Rt value
                rf_we_d    = 1'b1;
                swap_sel_d = 1'b1;
                wr_data_d  = tmp_rt_d;
            end
            WR_RT: begin
                // Rt slot receives the old Rs value
                rf_we_d    = 1'b1;
                swap_sel_d = 1'b0;
                wr_data_d  = tmp_rs_d;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q    <= IDLE;
            swap_a_q   <= {ADDR_W{1'b0}};
            swap_b_q   <= {ADDR_W{1'b0}};
            tmp_rs_q   <= {DATA_W{1'b0}};
            tmp_rt_q   <= {DATA_W{1'b0}};
            swap_sel_q <= 1'b0;
            rf_we_q    <= 1'b0;
            wr_data_q  <= {DATA_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            swap_a_q   <= swap_a_d;
            swap_b_q   <= swap_b_d;
            tmp_rs_q   <= tmp_rs_d;
            tmp_rt_q   <= tmp_rt_d;
            swap_sel_q <= swap_sel_d;
            rf_we_q    <= rf_we_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign swap_a   = swap_a_q;
    assign swap_b   = swap_b_q;
    assign swap_sel = swap_sel_q;
    assign rf_we    = rf_we_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule : swap_ctrl

// File: tb/tb_swap_ctrl.sv
// Self-checking bench for swap_ctrl: a per-cycle schedule model of a swap
// (offset from the accepting edge) plus directed literal expectations.
module tb_swap_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk;
    logic          rst_f;
    logic          start;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] rd_data_1;
    logic [DW-1:0] rd_data_2;
    logic [AW-1:0] swap_a;
    logic [AW-1:0] swap_b;
    logic          swap_sel;
    logic          rf_we;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;

    int passed = 0;
    int total  = 0;

    swap_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .start    (start),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rd_data_1(rd_data_1),
        .rd_data_2(rd_data_2),
        .swap_a   (swap_a),
        .swap_b   (swap_b),
        .swap_sel (swap_sel),
        .rf_we    (rf_we),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model: a swap accepted at an edge occupies the following len cycles
    // (len = 4, or 2 for Rs==Rt). Offset 1 reads, offsets 2/3 write, last is done.
    int            m_off   = 0;
    int            m_len   = 0;
    logic [AW-1:0] m_a     = '0;
    logic [AW-1:0] m_b     = '0;
    logic [DW-1:0] m_vrs   = '0;
    logic [DW-1:0] m_vrt   = '0;
    bit            m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_f) begin
            m_off   <= 0;
            m_len   <= 0;
            m_a     <= '0;
            m_b     <= '0;
            m_valid <= 1'b1;
        end else if (m_off == 0) begin
            if (start) begin
                m_a   <= rs_addr;
                m_b   <= rt_addr;
                m_len <= (rs_addr == rt_addr) ? 2 : 4;
                m_off <= 1;
            end
        end else begin
            if (m_off == 1) begin
                m_vrs <= rd_data_1;
                m_vrt <= rd_data_2;
            end
            m_off <= (m_off == m_len) ? 0 : m_off + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic          e_we;
        logic          e_sel;
        logic [DW-1:0] e_wr;
        if (m_valid) begin
            e_we  = (m_len == 4) && (m_off == 2 || m_off == 3);
            e_sel = (m_len == 4) && (m_off == 2);
            e_wr  = !e_we ? 32'h0 : (m_off == 2 ? m_vrt : m_vrs);
            chk("m_busy",   32'(busy),     32'(m_off != 0));
            chk("m_done",   32'(done),     32'(m_off != 0 && m_off == m_len));
            chk("m_rf_we",  32'(rf_we),    32'(e_we));
            chk("m_sel",    32'(swap_sel), 32'(e_sel));
            chk("m_wdata",  wr_data,       e_wr);
            chk("m_swap_a", 32'(swap_a),   32'(m_a));
            chk("m_swap_b", 32'(swap_b),   32'(m_b));
        end
    end

    initial begin
        int busy_cnt;
        rst_f     = 1'b0;
        start     = 1'b0;
        rs_addr   = 4'd0;
        rt_addr   = 4'd0;
        rd_data_1 = 32'hDEAD_0001;
        rd_data_2 = 32'hDEAD_0002;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we",   32'(rf_we), 32'd0);
        rst_f = 1'b1;
        tick();

        // Basic swap Rs=3 Rt=7, with a start re-pulse while busy
        start = 1'b1; rs_addr = 4'd3; rt_addr = 4'd7;
        tick();
        start = 1'b0; rd_data_1 = 32'h1111_1111; rd_data_2 = 32'h2222_2222;
        chk("basic_busy1", 32'(busy), 32'd1);
        tick();
        rd_data_1 = 32'hBAD0_0001; rd_data_2 = 32'hBAD0_0002;
        start = 1'b1; rs_addr = 4'd9; rt_addr = 4'd9;
        chk("basic_wrs_we",   32'(rf_we), 32'd1);
        chk("basic_wrs_sel",  32'(swap_sel), 32'd1);
        chk("basic_wrs_data", wr_data, 32'h2222_2222);
        tick();
        start = 1'b0;
        chk("basic_wrt_sel",  32'(swap_sel), 32'd0);
        chk("basic_wrt_data", wr_data, 32'h1111_1111);
        chk("busy_start_a",   32'(swap_a), 32'd3);
        tick();
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_done_we", 32'(rf_we), 32'd0);
        tick();
        chk("basic_idle", 32'(busy), 32'd0);
        chk("hold_a", 32'(swap_a), 32'd3);
        chk("hold_b", 32'(swap_b), 32'd7);

        // Back-to-back: start in the cycle right after done
        start = 1'b1; rs_addr = 4'd1; rt_addr = 4'd2;
        tick();
        start = 1'b0; rd_data_1 = 32'hA5A5_A5A5; rd_data_2 = 32'h5A5A_5A5A;
        tick();
        rd_data_1 = 32'hBAD0_0003; rd_data_2 = 32'hBAD0_0004;
        chk("b2b_wrs_data", wr_data, 32'h5A5A_5A5A);
        tick();
        chk("b2b_wrt_data", wr_data, 32'hA5A5_A5A5);
        tick();
        chk("b2b_done", 32'(done), 32'd1);
        tick();

        // Equal registers: no writes, done two cycles after start
        start = 1'b1; rs_addr = 4'd5; rt_addr = 4'd5;
        tick();
        start = 1'b0; rd_data_1 = 32'h3333_3333; rd_data_2 = 32'h3333_3333;
        chk("eq_we1", 32'(rf_we), 32'd0);
        tick();
        chk("eq_done", 32'(done), 32'd1);
        chk("eq_we2", 32'(rf_we), 32'd0);
        tick();
        chk("eq_idle", 32'(busy), 32'd0);

        // Mid-operation reset during WR_RS, start held high while in reset
        start = 1'b1; rs_addr = 4'd4; rt_addr = 4'd6;
        tick();
        start = 1'b0; rd_data_1 = 32'h4444_4444; rd_data_2 = 32'h6666_6666;
        tick();
        chk("mid_wrs_we", 32'(rf_we), 32'd1);
        rst_f = 1'b0; start = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_we",   32'(rf_we), 32'd0);
        chk("mid_rst_data", wr_data, 32'd0);
        chk("mid_rst_a",    32'(swap_a), 32'd0);
        rst_f = 1'b1; start = 1'b0;
        tick();
        chk("mid_no_done", 32'(done), 32'd0);
        chk("mid_no_busy", 32'(busy), 32'd0);

        // Boundary addresses Rs=0 Rt=15, extreme data; count busy cycles
        start = 1'b1; rs_addr = 4'd0; rt_addr = 4'd15;
        busy_cnt = 0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (i == 1) begin
                start = 1'b0; rd_data_1 = 32'hFFFF_FFFF; rd_data_2 = 32'h0000_0000;
            end else if (i == 2) begin
                rd_data_1 = 32'h1234_5678; rd_data_2 = 32'h8765_4321;
                chk("bnd_wrs_data", wr_data, 32'h0000_0000);
                chk("bnd_wrs_sel",  32'(swap_sel), 32'd1);
                chk("bnd_a",        32'(swap_a), 32'd0);
            end else if (i == 3) begin
                chk("bnd_wrt_data", wr_data, 32'hFFFF_FFFF);
                chk("bnd_b",        32'(swap_b), 32'd15);
            end
        end
        chk("bnd_busy_cycles", 32'(busy_cnt), 32'd4);

        tick();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_swap_ctrl
